pipelined_data_memory: RTL and testbench

PIPELINED_DATA_MEMORY -- requirements
Module: pipelined_data_memory

---
 rtl/pipelined_data_memory.sv | 174 +++++++++++++++++
 tb/tb_pipelined_data_memory.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_data_memory.sv
// Byte-addressable data memory behind a valid/ready request/response pair.
// Each access completes a fixed LATENCY edges after it is accepted; one request is in flight at a time.
module pipelined_data_memory #(
  parameter int                AWIDTH      = 32,
  parameter int                DWIDTH      = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR   = 32'h0100_0000,
  parameter int                DEPTH_BYTES = 1048576,
  parameter int                LATENCY     = 2,
  parameter string             INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int              NWORDS  = DEPTH_BYTES / 4;
  localparam int              IDXW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int              CNTW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH+1)'(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [AWIDTH-1:0]   addr_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic                we_q;
  logic [2:0]          f3_q;

  logic [DWIDTH-1:0]   mem_q [NWORDS] = '{default: '0};

  function automatic logic [DWIDTH-1:0] load_ext(input logic [DWIDTH-1:0] sh,
                                                 input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b010:  return sh;
      3'b100:  return {24'b0, sh[7:0]};
      3'b101:  return {16'b0, sh[15:0]};
      default: return '0;
    endcase
  endfunction

  logic                accept, enter_resp;
  logic [AWIDTH-1:0]   acc_addr, offset;
  logic [DWIDTH-1:0]   acc_wdata;
  logic                acc_we;
  logic [2:0]          acc_f3;
  logic [2:0]          acc_sz;
  logic [AWIDTH:0]     end_off;
  logic                bad_f3, acc_err;
  logic [IDXW-1:0]     widx;
  logic [1:0]          lane;
  logic [DWIDTH-1:0]   rd_word, rd_sh, wd_sh;
  logic [3:0]          be, be_sh;
  logic                mem_we;

  assign accept     = req_valid_i && req_ready_o;
  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  // With LATENCY=1 the access happens on the accept edge, so it must see the live request.
  always_comb begin
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_we    = we_q;
    acc_f3    = f3_q;
    if (state_q == IDLE) begin
      acc_addr  = req_addr_i;
      acc_wdata = req_wdata_i;
      acc_we    = req_we_i;
      acc_f3    = req_funct3_i;
    end
  end

  always_comb begin
    offset  = acc_addr - BASE_ADDR;
    acc_sz  = (acc_f3[1:0] == 2'b00) ? 3'd1 : (acc_f3[1:0] == 2'b01) ? 3'd2 : 3'd4;
    end_off = {1'b0, offset} + {{(AWIDTH-2){1'b0}}, acc_sz};
    if (acc_we) bad_f3 = (acc_f3 > 3'b010);
    else        bad_f3 = !(acc_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    acc_err = (acc_addr < BASE_ADDR) || (end_off > DEPTH_L) || bad_f3
           || ((acc_f3[1:0] == 2'b01) && acc_addr[0])
           || ((acc_f3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
    widx    = offset[IDXW+1:2];
    lane    = offset[1:0];
    rd_word = mem_q[widx];
    rd_sh   = rd_word >> {lane, 3'b000};
    wd_sh   = acc_wdata << {lane, 3'b000};
    be      = (acc_f3[1:0] == 2'b00) ? 4'b0001 : (acc_f3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
    be_sh   = be << lane;
    mem_we  = enter_resp && acc_we && !acc_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
      we_q    <= req_we_i;
      f3_q    <= req_funct3_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        if (LATENCY > 1) begin
          state_d = WAIT;
          cnt_d   = CNTW'(LATENCY - 1);
        end else begin
          state_d = RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNTW'(1)) state_d = RESP;
      end
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response is latched once on entry to RESP and held until the handshake.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_we) ? '0 : load_ext(rd_sh, acc_f3);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (be_sh[k]) mem_q[widx][8*k +: 8] <= wd_sh[8*k +: 8];
      end
    end
  end

  always_comb begin
    req_ready_o = (state_q == IDLE) && !rst;
    rsp_valid_o = (state_q == RESP);
    rsp_rdata_o = rdata_q;
    rsp_err_o   = err_q;
  end

endmodule

// File: tb/tb_pipelined_data_memory.sv
// Bench for pipelined_data_memory: LATENCY=2 instance driven by directed and random requests,
// LATENCY=1 instance streamed back-to-back; both checked against a byte-level reference model.
module tb_pipelined_data_memory;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam longint      DEPTH = 1048576;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v2 = 0, rdy2, we2 = 0, rv2, rr2 = 0, er2;
  logic [31:0] a2 = 0, wd2 = 0, rd2;
  logic [2:0]  f32 = 0;
  logic        v1 = 0, rdy1, we1 = 0, rv1, rr1 = 1'b1, er1;
  logic [31:0] a1 = 0, wd1 = 0, rd1;
  logic [2:0]  f31 = 0;

  pipelined_data_memory #(.LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid_i(v2), .req_ready_o(rdy2), .req_addr_i(a2),
    .req_wdata_i(wd2), .req_we_i(we2), .req_funct3_i(f32), .rsp_valid_o(rv2),
    .rsp_ready_i(rr2), .rsp_rdata_o(rd2), .rsp_err_o(er2));

  pipelined_data_memory #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid_i(v1), .req_ready_o(rdy1), .req_addr_i(a1),
    .req_wdata_i(wd1), .req_we_i(we1), .req_funct3_i(f31), .rsp_valid_o(rv1),
    .rsp_ready_i(rr1), .rsp_rdata_o(rd1), .rsp_err_o(er1));

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    check(nm, {31'b0, act}, {31'b0, exp});
  endtask

  // Reference memory: sparse byte arrays, unwritten bytes read as zero.
  logic [7:0] mb2 [longint];
  logic [7:0] mb1 [longint];

  function automatic logic [7:0] memr(input int bank, input longint o);
    if (bank == 0) return mb2.exists(o) ? mb2[o] : 8'h00;
    return mb1.exists(o) ? mb1[o] : 8'h00;
  endfunction

  function automatic void model(input int bank, input logic [31:0] a, input logic [31:0] wd,
                                input logic we, input logic [2:0] f3,
                                output logic [31:0] rd, output logic er);
    longint off, sz;
    logic [31:0] v;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    er = 1'b0;
    if (we && f3 > 3'd2) er = 1'b1;
    if (!we && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) er = 1'b1;
    if (a < BASE) er = 1'b1;
    off = longint'(a) - longint'(BASE);
    if (off + sz > DEPTH) er = 1'b1;
    if (sz == 2 && (a % 2) != 0) er = 1'b1;
    if (sz == 4 && (a % 4) != 0) er = 1'b1;
    rd = 32'h0;
    if (!er) begin
      if (we) begin
        for (int k = 0; k < sz; k++) begin
          if (bank == 0) mb2[off + k] = wd[8*k +: 8];
          else           mb1[off + k] = wd[8*k +: 8];
        end
      end else begin
        v = 32'h0;
        for (int k = 0; k < sz; k++) v = v | (32'(memr(bank, off + k)) << (8 * k));
        case (f3)
          3'd0:    rd = v[7] ? (v | 32'hFFFF_FF00) : v;
          3'd1:    rd = v[15] ? (v | 32'hFFFF_0000) : v;
          default: rd = v;
        endcase
      end
    end
  endfunction

  logic [31:0] exp_rd2;
  logic        exp_er2;
  bit          mon2 = 0;
  logic [32:0] q1 [$];
  logic [32:0] e1;
  int          n1 = 0, last1 = -1;

  // Single compare process: every cycle a response is presented it must match the model.
  always @(negedge clk) begin
    if (!rst && rv2 && mon2) begin
      check("rsp2_rdata", rd2, exp_rd2);
      check1("rsp2_err", er2, exp_er2);
    end
    if (!rst && rv1) begin
      if (q1.size() == 0) check1("rsp1_unexpected", rv1, 1'b0);
      else begin
        e1 = q1.pop_front();
        check("rsp1_rdata", rd1, e1[31:0]);
        check1("rsp1_err", er1, e1[32]);
        if (last1 >= 0) check("rsp1_gap", cyc - last1, 32'd2);
        last1 = cyc;
        n1++;
      end
    end
  end

  task automatic req2(input logic [31:0] a, input logic [31:0] wd, input logic we,
                      input logic [2:0] f3, input int hold,
                      output logic [31:0] rd, output logic er);
    int n, lat;
    @(negedge clk);
    v2 = 1; a2 = a; wd2 = wd; we2 = we; f32 = f3; rr2 = 0;
    n = 0;
    while (!rdy2 && n < 20) begin @(negedge clk); n++; end
    if (!rdy2) begin
      check1("req2_ready_timeout", rdy2, 1'b1);
      v2 = 0; rd = '0; er = 1'b1;
      return;
    end
    model(0, a, wd, we, f3, exp_rd2, exp_er2);
    mon2 = 1;
    @(posedge clk); #1;
    v2 = 0; a2 = $urandom; wd2 = $urandom; we2 = 1'($urandom_range(0, 1));
    f32 = 3'($urandom_range(0, 7));
    lat = 1;
    while (!rv2 && lat < 10) begin @(posedge clk); #1; lat++; end
    check("latency2", lat, 32'd2);
    repeat (hold) begin
      @(negedge clk);
      check1("hold_valid", rv2, 1'b1);
      check1("hold_ready", rdy2, 1'b0);
    end
    @(negedge clk);
    rd = rd2; er = er2; rr2 = 1;
    @(posedge clk); #1;
    rr2 = 0;
    check1("after_hs_valid", rv2, 1'b0);
    check1("after_hs_ready", rdy2, 1'b1);
    mon2 = 0;
  endtask

  function automatic logic [2:0] rand_f3();
    if ($urandom_range(0, 4) == 0) return 3'($urandom_range(0, 7));
    case ($urandom_range(0, 4))
      0: return 3'd0;
      1: return 3'd1;
      2: return 3'd2;
      3: return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return BASE + 32'($urandom_range(0, 63));
      6, 7:             return BASE + 32'(DEPTH) - 32'd8 + 32'($urandom_range(0, 15));
      8:                return BASE - 32'($urandom_range(1, 4));
      default:          return $urandom;
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] rd;
  logic        er, eer;
  logic [31:0] erd;
  int          sent, issued;

  initial begin
    repeat (3) @(negedge clk);
    check1("rst_ready2", rdy2, 1'b0);
    check1("rst_valid2", rv2, 1'b0);
    check("rst_rdata2", rd2, 32'h0);
    check1("rst_err2", er2, 1'b0);
    check1("rst_ready1", rdy1, 1'b0);
    rst = 0;
    #1;
    check1("post_rst_ready2", rdy2, 1'b1);
    check1("post_rst_ready1", rdy1, 1'b1);

    req2(32'h0100_0010, 32'hDEAD_BEEF, 1, 3'b010, 0, rd, er);
    check("sw_rdata", rd, 32'h0);
    check1("sw_err", er, 1'b0);
    req2(32'h0100_0010, 32'h0, 0, 3'b010, 0, rd, er);
    check("lw_lit", rd, 32'hDEAD_BEEF);
    req2(32'h0100_0013, 32'h0000_0080, 1, 3'b000, 0, rd, er);
    req2(32'h0100_0013, 32'h0, 0, 3'b000, 0, rd, er);
    check("lb_lit", rd, 32'hFFFF_FF80);
    req2(32'h0100_0013, 32'h0, 0, 3'b100, 0, rd, er);
    check("lbu_lit", rd, 32'h0000_0080);
    req2(32'h0100_0010, 32'h0, 0, 3'b010, 0, rd, er);
    check("lw_merged_lit", rd, 32'h80AD_BEEF);
    req2(32'h0100_0011, 32'h0, 0, 3'b001, 0, rd, er);
    check1("lh_misalign_err", er, 1'b1);
    check("lh_misalign_rdata", rd, 32'h0);
    req2(32'h00FF_FFFC, 32'hCAFE_F00D, 1, 3'b010, 0, rd, er);
    check1("sw_below_err", er, 1'b1);
    req2(BASE + 32'(DEPTH) - 32'd4, 32'hA5A5_5A5A, 1, 3'b010, 0, rd, er);
    check1("sw_last_err", er, 1'b0);
    req2(BASE + 32'(DEPTH) - 32'd4, 32'h0, 0, 3'b010, 5, rd, er);
    check("lw_last_lit", rd, 32'hA5A5_5A5A);
    req2(BASE, 32'h0, 0, 3'b010, 0, rd, er);
    check("lw_base_lit", rd, 32'h0);

    // Reset lands between accept and commit: the store must vanish.
    @(negedge clk);
    v2 = 1; a2 = 32'h0100_0020; wd2 = 32'h1234_5678; we2 = 1; f32 = 3'b010;
    check1("abort_ready", rdy2, 1'b1);
    @(posedge clk); #1;
    v2 = 0; rst = 1;
    #1;
    check1("abort_rst_valid", rv2, 1'b0);
    check1("abort_rst_ready", rdy2, 1'b0);
    @(negedge clk);
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      check1("abort_no_rsp", rv2, 1'b0);
    end
    req2(32'h0100_0020, 32'h0, 0, 3'b010, 0, rd, er);
    check("abort_lw_lit", rd, 32'h0);
    req2(32'h0100_0010, 32'h0, 0, 3'b010, 0, rd, er);
    check("abort_keep_lit", rd, 32'h80AD_BEEF);

    for (int i = 0; i < 150; i++) begin
      req2(rand_addr(), $urandom, 1'($urandom_range(0, 1)), rand_f3(),
           $urandom_range(0, 2), rd, er);
    end

    // LATENCY=1 stream with the consumer always ready.
    a1 = BASE + 32'($urandom_range(0, 7) * 4); wd1 = $urandom; we1 = 1; f31 = 3'b010;
    v1 = 1; sent = 0; issued = 0;
    for (int c = 0; c < 400 && n1 < 30; c++) begin
      @(negedge clk);
      if (v1 && rdy1) begin
        model(1, a1, wd1, we1, f31, erd, eer);
        q1.push_back({eer, erd});
        sent++;
        issued = 1;
      end else if (issued != 0) begin
        issued = 0;
        if (sent < 30) begin
          we1 = (sent < 8);
          f31 = we1 ? 3'($urandom_range(0, 2)) : rand_f3();
          a1  = BASE + 32'($urandom_range(0, 31));
          wd1 = $urandom;
        end else begin
          v1 = 0;
        end
      end
    end
    v1 = 0;
    check("rsp1_count", n1, 32'd30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
